pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match sequencer for the Pong game. It sits between the VGA sync generator, the ball datapath and the score display. It gates ball motion and recenters the ball between rallies. It counts points per player, declares a winner at a configurable score, and paces all pauses in whole video frames.

## Interface
Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frames the ball is held still before each rally; legal range 1..255.
- POINT_FRAMES, 90: frames of pause after a point is scored; legal range 1..255.

Ports:
- clk_in  in  1: pixel clock. Single clock domain.
- i_rst  in  1: reset, synchronous, active-high.
- frame_end  in  1: one-cycle pulse when o_x==639 and o_y==479.
- btn_start  in  1: start button, level, already debounced.
- pointPlayer1  in  1: ball datapath reports that player 1 scored.
- pointPlayer2  in  1: ball datapath reports that player 2 scored.
- ball_run  out  1: high means the ball datapath may update its position.
- ball_reset  out  1: one-cycle pulse that recenters the ball.
- serve_dir  out  1: initial ball direction. 0 = right, 1 = left.
- score1  out  4: player 1 score.
- score2  out  4: player 2 score.
- winner  out  2: 00 = none, 01 = player 1, 10 = player 2.
- state_o  out  3: current state, for debug.

## Operation
- States and encodings: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, GAMEOVER = 4.
- Start detection: btn_start is registered once and compared with its delayed copy. A 0→1 edge produces one internal `start` pulse.
- Frame counter: 8 bits. Cleared on every state entry. Increments on each frame_end in SERVE and POINT.
- IDLE
  - ball_run = 0.
  - On `start`: score1 ← 0, score2 ← 0, winner ← 00, serve_dir ← 0, pulse ball_reset, go to SERVE.
- SERVE
  - ball_run = 0.
  - When frame_end is high and the counter equals SERVE_FRAMES−1, go to PLAY.
- PLAY
  - ball_run = 1.
  - On pointPlayer1: score1 ← score1+1, serve_dir ← 0 (served toward player 2), go to POINT.
  - Else on pointPlayer2: score2 ← score2+1, serve_dir ← 1, go to POINT.
  - If both are high in the same cycle, player 1 has priority and only score1 increments.
- POINT
  - ball_run = 0.
  - Wait until frame_end is high and the counter equals POINT_FRAMES−1. Then:
    - if score1 ≥ WIN_SCORE: winner ← 01, go to GAMEOVER;
    - else if score2 ≥ WIN_SCORE: winner ← 10, go to GAMEOVER;
    - otherwise pulse ball_reset and go to SERVE.
- GAMEOVER
  - ball_run = 0. Scores and winner are held.
  - On `start`: perform the IDLE start action and go to SERVE.
- pointPlayer1/2 are ignored in every state except PLAY.
- btn_start is ignored in SERVE, PLAY and POINT.
- Scores are 4-bit and never exceed WIN_SCORE, so no wrap-around can occur.

## Timing
- Reset values of all outputs: ball_run = 0, ball_reset = 0, serve_dir = 0, score1 = 0, score2 = 0, winner = 00, state_o = IDLE. The frame counter is 0 and the start edge registers are 0.
- i_rst dominates every other input in the same cycle.
- Reset asserted mid-rally puts the block in IDLE at the next edge with all outputs at reset values.
- All outputs are registered. Each takes its new value on the clock edge that samples the qualifying input, so outputs lag that input by one cycle.
- Start latency: `start` appears one cycle after the btn_start rising edge. The outputs then update on the following edge, two cycles after the btn_start edge.
- ball_reset is high for exactly one cycle. It is asserted on the same edge that enters SERVE.
- SERVE lasts exactly SERVE_FRAMES frame_end pulses. ball_run rises on the edge that samples the last of those pulses.
- POINT lasts exactly POINT_FRAMES frame_end pulses.
- A point input held high for many cycles counts once, because the FSM leaves PLAY on the first cycle it is sampled.
- frame_end in the same cycle as a point input in PLAY has no effect; the point is taken.

## Test plan
- Reset, then btn_start 0→1 → two cycles later ball_reset pulses for one cycle, state_o = 1, scores = 0, ball_run = 0. With SERVE_FRAMES = 3, ball_run = 1 after the 3rd frame_end.
- In PLAY, pulse pointPlayer2 → score2 = 1, serve_dir = 1, ball_run = 0. After POINT_FRAMES frame_end pulses, ball_reset pulses and state_o = SERVE.
- Assert pointPlayer1 and pointPlayer2 in the same cycle → score1 = 1, score2 = 0, serve_dir = 0.
- WIN_SCORE = 2: player 1 scores twice → after the POINT wait, winner = 01, state_o = 4, no ball_reset pulse. Then btn_start → scores = 0, winner = 00, SERVE.
- Pulse pointPlayer1 during SERVE and btn_start during PLAY → no score or state change.
- Assert i_rst mid-PLAY with score1 = 3 → next cycle all outputs are at reset values and state_o = IDLE.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: gates ball motion, keeps score, declares a winner,
// and paces serve/point pauses in whole video frames.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       frame_end,
  input  logic       btn_start,
  input  logic       pointPlayer1,
  input  logic       pointPlayer2,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] POINT_LAST = CW'(POINT_FRAMES - 1);
  localparam logic [SW-1:0] WIN_PTS    = SW'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          btn_dly_q, btn_dly_d;
  logic [SW-1:0] score1_q, score1_d;
  logic [SW-1:0] score2_q, score2_d;
  logic [1:0]    winner_q, winner_d;
  logic          serve_dir_q, serve_dir_d;
  logic          ball_reset_q, ball_reset_d;
  logic          ball_run_q, ball_run_d;
  logic          start_c;

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      btn_q        <= 1'b0;
      btn_dly_q    <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      ball_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_q        <= btn_d;
      btn_dly_q    <= btn_dly_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      ball_reset_q <= ball_reset_d;
      ball_run_q   <= ball_run_d;
    end
  end

  assign start_c = btn_q & ~btn_dly_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    btn_d        = btn_start;
    btn_dly_d    = btn_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_reset_d = 1'b0;

    case (state_q)
      IDLE, GAMEOVER: begin
        if (start_c) begin
          score1_d     = '0;
          score2_d     = '0;
          winner_d     = 2'b00;
          serve_dir_d  = 1'b0;
          ball_reset_d = 1'b1;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        if (frame_end) begin
          if (cnt_q == SERVE_LAST) state_d = PLAY;
          else                     cnt_d   = cnt_q + CW'(1);
        end
      end
      PLAY: begin
        // Player 1 wins a simultaneous report; frame_end is irrelevant here.
        if (pointPlayer1) begin
          score1_d    = score1_q + SW'(1);
          serve_dir_d = 1'b0;
          state_d     = POINT;
        end else if (pointPlayer2) begin
          score2_d    = score2_q + SW'(1);
          serve_dir_d = 1'b1;
          state_d     = POINT;
        end
      end
      POINT: begin
        if (frame_end) begin
          if (cnt_q == POINT_LAST) begin
            if (score1_q >= WIN_PTS) begin
              winner_d = 2'b01;
              state_d  = GAMEOVER;
            end else if (score2_q >= WIN_PTS) begin
              winner_d = 2'b10;
              state_d  = GAMEOVER;
            end else begin
              ball_reset_d = 1'b1;
              state_d      = SERVE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts the frame pacing from zero.
    if (state_d != state_q) cnt_d = '0;
    ball_run_d = (state_d == PLAY);
  end

  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed vector table, hand-written
// corner sequences, and a randomized run against a countdown-based model.
module tb_pong_match_ctrl;

  localparam int unsigned WIN = 4;
  localparam int unsigned SF  = 3;
  localparam int unsigned PF  = 2;

  logic       clk = 1'b0;
  logic       rst, fe, btn, p1, p2;
  logic       ball_run, ball_reset, serve_dir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk_in(clk), .i_rst(rst), .frame_end(fe), .btn_start(btn),
    .pointPlayer1(p1), .pointPlayer2(p2),
    .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase uses the documented state numbers, pauses count down.
  int m_phase, m_left, m_s1, m_s2, m_win;
  bit m_dir, m_rb, m_hist1, m_hist2;

  function automatic void model_step(bit r, bit f, bit b, bit a1, bit a2);
    bit start;
    if (r) begin
      m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_dir = 0; m_rb = 0; m_hist1 = 0; m_hist2 = 0;
      return;
    end
    start   = m_hist1 && !m_hist2;
    m_hist2 = m_hist1;
    m_hist1 = b;
    m_rb    = 0;
    case (m_phase)
      0, 4: if (start) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_rb = 1;
        m_phase = 1; m_left = SF;
      end
      1: if (f) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: if (a1) begin
        m_s1++; m_dir = 0; m_phase = 3; m_left = PF;
      end else if (a2) begin
        m_s2++; m_dir = 1; m_phase = 3; m_left = PF;
      end
      3: if (f) begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 >= WIN)      begin m_win = 1; m_phase = 4; end
          else if (m_s2 >= WIN) begin m_win = 2; m_phase = 4; end
          else begin m_rb = 1; m_phase = 1; m_left = SF; end
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit r, bit f, bit b, bit a1, bit a2);
    rst = r; fe = f; btn = b; p1 = a1; p2 = a2;
    @(posedge clk);
    model_step(r, f, b, a1, a2);
    #1;
  endtask

  task automatic check_all(string name, int st, int run, int rb, int s1, int s2,
                           int dir, int win);
    check({name, ".state"}, int'(state_o), st);
    check({name, ".run"}, int'(ball_run), run);
    check({name, ".ball_reset"}, int'(ball_reset), rb);
    check({name, ".score1"}, int'(score1), s1);
    check({name, ".score2"}, int'(score2), s2);
    check({name, ".serve_dir"}, int'(serve_dir), dir);
    check({name, ".winner"}, int'(winner), win);
  endtask

  task automatic start_to_play();
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < int'(SF); i++) tick(0, 1, 0, 0, 0);
  endtask

  task automatic p1_point();
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < int'(PF); i++) tick(0, 1, 0, 0, 0);
  endtask

  typedef struct {
    bit r, f, b, a1, a2;
    int st, run, rb, s1, s2, dir;
  } vec_t;

  vec_t vecs[16];

  initial begin
    rst = 1; fe = 0; btn = 0; p1 = 0; p2 = 0;
    //          r f b a1 a2  st run rb s1 s2 dir
    vecs[0]  = '{1,0,0,0,0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0,0,1,0,0,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0,0,1,0,0,  1, 0, 1, 0, 0, 0};
    vecs[3]  = '{0,1,0,0,0,  1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0,0,0,1,0,  1, 0, 0, 0, 0, 0};
    vecs[5]  = '{0,1,0,0,0,  1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0,1,0,0,0,  2, 1, 0, 0, 0, 0};
    vecs[7]  = '{0,0,1,0,0,  2, 1, 0, 0, 0, 0};
    vecs[8]  = '{0,1,0,0,1,  3, 0, 0, 0, 1, 1};
    vecs[9]  = '{0,0,0,0,1,  3, 0, 0, 0, 1, 1};
    vecs[10] = '{0,1,0,0,0,  3, 0, 0, 0, 1, 1};
    vecs[11] = '{0,1,0,0,0,  1, 0, 1, 0, 1, 1};
    vecs[12] = '{0,1,0,0,0,  1, 0, 0, 0, 1, 1};
    vecs[13] = '{0,1,0,0,0,  1, 0, 0, 0, 1, 1};
    vecs[14] = '{0,1,0,0,0,  2, 1, 0, 0, 1, 1};
    vecs[15] = '{0,0,0,1,1,  3, 0, 0, 1, 1, 0};

    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].a1, vecs[i].a2);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].run, vecs[i].rb,
                vecs[i].s1, vecs[i].s2, vecs[i].dir, 0);
    end

    // Reset in the middle of a rally with score1 = 3.
    tick(1, 0, 0, 0, 0);
    start_to_play();
    check("serve_to_play.state", int'(state_o), 2);
    for (int k = 0; k < 3; k++) begin
      p1_point();
      for (int i = 0; i < int'(SF); i++) tick(0, 1, 0, 0, 0);
    end
    check("mid_play.score1", int'(score1), 3);
    check("mid_play.state", int'(state_o), 2);
    tick(1, 1, 1, 1, 0);
    check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0);

    // Full match to WIN points for player 1, then restart from GAMEOVER.
    start_to_play();
    for (int k = 0; k < int'(WIN) - 1; k++) begin
      p1_point();
      for (int i = 0; i < int'(SF); i++) tick(0, 1, 0, 0, 0);
    end
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    check("win.pre_state", int'(state_o), 3);
    tick(0, 1, 0, 0, 0);
    check_all("win", 4, 0, 0, int'(WIN), 0, 0, 1);
    tick(0, 1, 0, 1, 1);
    check_all("gameover_hold", 4, 0, 0, int'(WIN), 0, 0, 1);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    check_all("restart", 1, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    check("restart.pulse_once", int'(ball_reset), 0);

    // Randomized run against the model.
    tick(1, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      bit r, f, b, a1, a2;
      r  = ($urandom_range(0, 599) == 0);
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) < 3) ? ~btn : btn;
      a1 = ($urandom_range(0, 14) == 0);
      a2 = ($urandom_range(0, 14) == 0);
      tick(r, f, b, a1, a2);
      check("rand.outputs",
            {21'd0, state_o, ball_run, ball_reset, serve_dir, score1, score2, winner},
            {21'd0, 3'(m_phase), (m_phase == 2), m_rb, m_dir, 4'(m_s1), 4'(m_s2), 2'(m_win)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
